// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter for a single command byte.
// Inhibits the clock line, issues request-to-send, then shifts out an
// 11-bit frame on the device-generated clock and checks the device ACK.
// Optional transfer watchdog: define PS2TX_TIMEOUT_EN to build it.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for start, both lines released
// INHIBIT  | clock line held low for INHIBIT_US
// RTS      | clock released, data pulled low (start bit), one cycle
// SEND     | data/parity/stop shifted out on device clock falling edges
// ACK      | sample the device ACK bit on the next falling edge
// WAITIDLE | wait for clock and data both high, then signal done
module ps2_host_tx #(
   parameter int CLK_HZ     = 25000000,
   parameter int INHIBIT_US = 100,
   parameter int TIMEOUT_MS = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       rdy,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       ps2c_i,
   input  logic       ps2d_i,
   output logic       ps2c_oe,
   output logic       ps2d_oe
);

   localparam int INH_CYC = CLK_HZ / 1000000 * INHIBIT_US;
   localparam int INH_W   = (INH_CYC > 1) ? $clog2(INH_CYC) : 1;
   localparam int WD_LIM  = CLK_HZ / 1000 * TIMEOUT_MS;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_INHIBIT  = 3'd1;
   localparam logic [2:0] ST_RTS      = 3'd2;
   localparam logic [2:0] ST_SEND     = 3'd3;
   localparam logic [2:0] ST_ACK      = 3'd4;
   localparam logic [2:0] ST_WAITIDLE = 3'd5;

   // Reject parameter sets that would give an empty inhibit or watchdog window.
   if (INH_CYC < 1 || WD_LIM < 2) begin : g_bad_cfg
      $error("ps2_host_tx: CLK_HZ/INHIBIT_US/TIMEOUT_MS give an empty timing window");
   end

   // Input synchronizers and clock glitch filter
   logic       c_s1_q, c_s2_q;
   logic       d_s1_q, d_s2_q;
   logic       filt_q, filt_d;
   logic [1:0] fcnt_q, fcnt_d;
   logic       fe_q, fe_d;

   // FSM and datapath
   logic [2:0]       state_q, state_d;
   logic [INH_W-1:0] tmr_q, tmr_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [10:0]      sh_q, sh_d;
   logic             ps2c_oe_q, ps2c_oe_d;
   logic             ps2d_oe_q, ps2d_oe_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             wd_exp;

   // Two-flop synchronizers; idle bus level is high, so reset to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_s1_q <= 1'b1;
         c_s2_q <= 1'b1;
         d_s1_q <= 1'b1;
         d_s2_q <= 1'b1;
      end else begin
         c_s1_q <= ps2c_i;
         c_s2_q <= c_s1_q;
         d_s1_q <= ps2d_i;
         d_s2_q <= d_s1_q;
      end
   end

   // Filtered clock follows the synchronized clock after 4 stable cycles.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      if (c_s2_q == filt_q) begin
         fcnt_d = 2'd0;
      end else if (fcnt_q == 2'd3) begin
         filt_d = c_s2_q;
         fcnt_d = 2'd0;
      end else begin
         fcnt_d = fcnt_q + 2'd1;
      end
      fe_d = filt_q & ~filt_d;
   end

   // Filter state and one-cycle falling-edge strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= 1'b1;
         fcnt_q <= 2'd0;
         fe_q   <= 1'b0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
         fe_q   <= fe_d;
      end
   end

`ifdef PS2TX_TIMEOUT_EN
   localparam int WD_W = $clog2(WD_LIM);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            wd_run;

   // Watchdog counts while the device owns the clock; cleared elsewhere.
   always_comb begin
      wd_run = (state_q == ST_RTS) || (state_q == ST_SEND) ||
               (state_q == ST_ACK) || (state_q == ST_WAITIDLE);
      wd_d   = '0;
      if (wd_run && !wd_exp) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   assign wd_exp = wd_run && (wd_q == WD_W'(WD_LIM - 1));

   // Watchdog counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   assign wd_exp = 1'b0;
`endif

   // Transfer sequencing: next-state, line drive and status.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      ps2c_oe_d = ps2c_oe_q;
      ps2d_oe_d = ps2d_oe_q;
      err_d     = err_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ps2c_oe_d = 1'b0;
            ps2d_oe_d = 1'b0;
            if (start) begin
               sh_d      = {1'b1, ~^data, data, 1'b0};
               err_d     = 1'b0;
               tmr_d     = INH_W'(INH_CYC - 1);
               ps2c_oe_d = 1'b1;
               state_d   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (tmr_q == '0) begin
               // Clock release and start bit switch on the same edge.
               ps2c_oe_d = 1'b0;
               ps2d_oe_d = ~sh_q[0];
               state_d   = ST_RTS;
            end else begin
               tmr_d = tmr_q - INH_W'(1);
            end
         end
         ST_RTS: begin
            bit_cnt_d = 4'd0;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            if (fe_q) begin
               sh_d      = {1'b1, sh_q[10:1]};
               ps2d_oe_d = ~sh_q[1];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd9) begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            if (fe_q) begin
               if (d_s2_q) begin
                  err_d = 1'b1;
               end
               state_d = ST_WAITIDLE;
            end
         end
         ST_WAITIDLE: begin
            if (filt_q && d_s2_q) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            ps2c_oe_d = 1'b0;
            ps2d_oe_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase

      // Watchdog expiry overrides whatever the bus is doing.
      if (wd_exp) begin
         err_d     = 1'b1;
         ps2c_oe_d = 1'b0;
         ps2d_oe_d = 1'b0;
         done_d    = 1'b1;
         state_d   = ST_IDLE;
      end
   end

   // FSM registers; reset releases both lines asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tmr_q     <= '0;
         bit_cnt_q <= 4'd0;
         sh_q      <= '0;
         ps2c_oe_q <= 1'b0;
         ps2d_oe_q <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         bit_cnt_q <= bit_cnt_d;
         sh_q      <= sh_d;
         ps2c_oe_q <= ps2c_oe_d;
         ps2d_oe_q <= ps2d_oe_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   assign rdy     = (state_q == ST_IDLE);
   assign busy    = ~rdy;
   assign done    = done_q;
   assign err     = err_q;
   assign ps2c_oe = ps2c_oe_q;
   assign ps2d_oe = ps2d_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: open-drain bus with a PS/2 device model that
// clocks in host frames and optionally drives the ACK bit.
module tb_ps2_host_tx;

   localparam int CLK_HZ     = 1000000;
   localparam int INHIBIT_US = 100;
   localparam int TIMEOUT_MS = 15;
   localparam int INH_CYC    = 100;
   localparam int WD_CYC     = 15000;
   localparam int HP         = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] data = 8'h00;
   logic       rdy, busy, done, err;
   logic       ps2c_i, ps2d_i, ps2c_oe, ps2d_oe;
   logic       dev_c_low = 1'b0;
   logic       dev_d_low = 1'b0;

   assign ps2c_i = ~(ps2c_oe | dev_c_low);
   assign ps2d_i = ~(ps2d_oe | dev_d_low);

   ps2_host_tx #(
      .CLK_HZ     (CLK_HZ),
      .INHIBIT_US (INHIBIT_US),
      .TIMEOUT_MS (TIMEOUT_MS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .data    (data),
      .rdy     (rdy),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .ps2c_i  (ps2c_i),
      .ps2d_i  (ps2d_i),
      .ps2c_oe (ps2c_oe),
      .ps2d_oe (ps2d_oe)
   );

   always #5 clk = ~clk;

   int   n_pass = 0;
   int   n_total = 0;
   int   done_cnt = 0;
   logic err_at_done = 1'b0;

   always @(posedge clk) begin
      if (done === 1'b1) begin
         done_cnt    = done_cnt + 1;
         err_at_done = err;
      end
   end

   typedef struct {
      logic [7:0] d;
      bit         ack;
      bit         inj;
      logic [7:0] exp_byte;
      bit         exp_par;
      bit         exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end else begin
         n_pass = n_pass + 1;
      end
   endtask

   // Host frame with device model: start, inhibit, RTS, 11 device clocks.
   task automatic send_frame(input logic [7:0] d, input bit ack, input bit inj,
                             output logic [9:0] bits, output int d0);
      int n;
      bits = '0;
      d0   = done_cnt;
      @(negedge clk);
      data  = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("accept_rdy", rdy, 0);
      chk("accept_busy", busy, 1);
      chk("accept_c_oe", ps2c_oe, 1);
      chk("accept_err_clr", err, 0);
      n = 0;
      while (ps2c_oe === 1'b1 && n < 1000) begin
         n = n + 1;
         @(negedge clk);
      end
      chk("inhibit_len", n, INH_CYC);
      chk("rts_start_bit", ps2d_oe, 1);
      repeat (20) @(negedge clk);
      for (int e = 1; e <= 11; e++) begin
         dev_c_low = 1'b1;
         if (inj && e == 3) begin
            data  = 8'h55;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (HP - 1) @(negedge clk);
         end else begin
            repeat (HP) @(negedge clk);
         end
         dev_c_low = 1'b0;
         if (e == 11) begin
            dev_d_low = 1'b0;
         end else begin
            bits[e-1] = ps2d_i;
         end
         repeat (5) @(negedge clk);
         if (e == 10 && ack) dev_d_low = 1'b1;
         repeat (HP - 5) @(negedge clk);
      end
      n = 0;
      while (done_cnt == d0 && n < 500) begin
         n = n + 1;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      logic [9:0] bits;
      int         d0;
      int         n;

      vecs[0] = '{d: 8'hED, ack: 1'b1, inj: 1'b0, exp_byte: 8'hED, exp_par: 1'b1, exp_err: 1'b0};
      vecs[1] = '{d: 8'hF4, ack: 1'b1, inj: 1'b0, exp_byte: 8'hF4, exp_par: 1'b0, exp_err: 1'b0};
      vecs[2] = '{d: 8'h00, ack: 1'b1, inj: 1'b0, exp_byte: 8'h00, exp_par: 1'b1, exp_err: 1'b0};
      vecs[3] = '{d: 8'hFF, ack: 1'b1, inj: 1'b0, exp_byte: 8'hFF, exp_par: 1'b1, exp_err: 1'b0};
      vecs[4] = '{d: 8'hA5, ack: 1'b0, inj: 1'b0, exp_byte: 8'hA5, exp_par: 1'b1, exp_err: 1'b1};
      vecs[5] = '{d: 8'h3C, ack: 1'b1, inj: 1'b1, exp_byte: 8'h3C, exp_par: 1'b1, exp_err: 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_rdy", rdy, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_c_oe", ps2c_oe, 0);
      chk("rst_d_oe", ps2d_oe, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].d, vecs[i].ack, vecs[i].inj, bits, d0);
         chk($sformatf("v%0d_byte", i), bits[7:0], vecs[i].exp_byte);
         chk($sformatf("v%0d_parity", i), bits[8], vecs[i].exp_par);
         chk($sformatf("v%0d_stop", i), bits[9], 1);
         chk($sformatf("v%0d_done_once", i), done_cnt - d0, 1);
         chk($sformatf("v%0d_err_at_done", i), err_at_done, vecs[i].exp_err);
         chk($sformatf("v%0d_err_held", i), err, vecs[i].exp_err);
         chk($sformatf("v%0d_rdy_after", i), rdy, 1);
         chk($sformatf("v%0d_lines_free", i), {ps2c_oe, ps2d_oe}, 0);
      end

      // Reset during data bit 3 (fourth device clock): lines drop, no done.
      @(negedge clk);
      data  = 8'h52;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(ps2d_oe === 1'b1 && ps2c_oe === 1'b0) && n < 1000) begin
         n = n + 1;
         @(negedge clk);
      end
      chk("rstmid_rts_reached", (n < 1000), 1);
      repeat (20) @(negedge clk);
      for (int e = 1; e <= 3; e++) begin
         dev_c_low = 1'b1;
         repeat (HP) @(negedge clk);
         dev_c_low = 1'b0;
         repeat (HP) @(negedge clk);
      end
      dev_c_low = 1'b1;
      repeat (20) @(negedge clk);
      chk("rstmid_bit3_low", ps2d_oe, 1);
      d0 = done_cnt;
      #2 rst = 1'b1;
      #1;
      chk("rstmid_oe_async", {ps2c_oe, ps2d_oe}, 0);
      chk("rstmid_rdy", rdy, 1);
      dev_c_low = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("rstmid_no_done", done_cnt - d0, 0);

      send_frame(8'hED, 1'b1, 1'b0, bits, d0);
      chk("post_rst_byte", bits[7:0], 8'hED);
      chk("post_rst_parity", bits[8], 1);
      chk("post_rst_done", done_cnt - d0, 1);
      chk("post_rst_err", err, 0);

`ifdef PS2TX_TIMEOUT_EN
      // Silent device: watchdog ends the transfer after WD_CYC cycles.
      @(negedge clk);
      data  = 8'hF4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (ps2d_oe !== 1'b1 && n < 1000) begin
         n = n + 1;
         @(negedge clk);
      end
      n = 0;
      while (done !== 1'b1 && n < WD_CYC + 100) begin
         @(negedge clk);
         n = n + 1;
      end
      chk("wd_cycles", n, WD_CYC);
      chk("wd_err", err, 1);
      chk("wd_lines_free", {ps2c_oe, ps2d_oe}, 0);
      chk("wd_rdy", rdy, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
